// File: rtl/wbu_pkg.sv
// Shared types and sizes for the write-back unit: architectural widths and
// the pending-entry record carried through the write-back FIFO.
package wbu_pkg;

    localparam int XLEN      = 64;
    localparam int NR_REG    = 32;
    localparam int REG_IDX_W = 5;

    typedef struct packed {
        logic [XLEN-1:0]      pc;
        logic [XLEN-1:0]      res;
        logic [REG_IDX_W-1:0] rd;
        logic                 wen;
    } wb_entry_t;

endpackage

// File: rtl/wbu_regfile.sv
// Integer register file: NR_REG x N, one synchronous write port and two
// combinational read ports; register 0 reads as zero and ignores writes.
module wbu_regfile
    import wbu_pkg::*;
#(
    parameter int N      = XLEN,
    parameter int NR_REG = wbu_pkg::NR_REG
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 we,
    input  logic [REG_IDX_W-1:0] waddr,
    input  logic [N-1:0]         wdata,
    input  logic [REG_IDX_W-1:0] raddr1,
    output logic [N-1:0]         rdata1,
    input  logic [REG_IDX_W-1:0] raddr2,
    output logic [N-1:0]         rdata2
);

    logic [N-1:0] regs [NR_REG];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NR_REG; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (waddr != '0)) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata1 = (raddr1 == '0) ? '0 : regs[raddr1];
    assign rdata2 = (raddr2 == '0) ? '0 : regs[raddr2];

endmodule

// File: rtl/wbu.sv
// Write-back unit: in-order pending FIFO, retirement into the register file,
// commit pulse and operand read ports. Build option: WBU_BYPASS_EN.
module wbu
    import wbu_pkg::*;
#(
    parameter int N      = XLEN,
    parameter int NR_REG = wbu_pkg::NR_REG,
    parameter int DEPTH  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N-1:0]         in_res,
    input  logic [REG_IDX_W-1:0] in_rd,
    input  logic                 in_wen,
    input  logic [N-1:0]         in_pc,
    input  logic                 wb_stall,
    input  logic [REG_IDX_W-1:0] rs1_addr,
    output logic [N-1:0]         rs1_data,
    input  logic [REG_IDX_W-1:0] rs2_addr,
    output logic [N-1:0]         rs2_data,
    output logic                 rs1_hazard,
    output logic                 rs2_hazard,
    output logic                 commit_valid,
    output logic [N-1:0]         commit_pc
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    wb_entry_t        fifo [DEPTH];
    logic [PTR_W-1:0] head, tail;
    logic [CNT_W-1:0] count;
    logic             full, empty, enq, deq;
    logic [N-1:0]     rf_rdata1, rf_rdata2;
    logic [N:0]       pend1, pend2;

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    // Ready ignores a same-cycle dequeue so the accept path stays short.
    assign in_ready = !rst && !full;
    assign enq      = in_valid && in_ready;
    assign deq      = !empty && !wb_stall;

    // Youngest pending writer of addr, as {hit, res}; index 0 never matches.
    function automatic logic [N:0] pend_match(input logic [REG_IDX_W-1:0] addr);
        logic [N:0]       r;
        logic [PTR_W-1:0] idx;
        r = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PTR_W'(i);
            if ((CNT_W'(i) < count) && fifo[idx].wen &&
                (fifo[idx].rd == addr) && (addr != '0)) begin
                r = {1'b1, fifo[idx].res};
            end
        end
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (enq) tail <= tail + PTR_W'(1);
            if (deq) head <= head + PTR_W'(1);
            case ({enq, deq})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            fifo[tail] <= '{pc: in_pc, res: in_res, rd: in_rd, wen: in_wen};
        end
    end

    // Retire stage: commit pulse registered alongside the regfile write.
    always_ff @(posedge clk) begin
        if (rst) begin
            commit_valid <= 1'b0;
            commit_pc    <= '0;
        end else begin
            commit_valid <= deq;
            if (deq) commit_pc <= fifo[head].pc;
        end
    end

    wbu_regfile #(.N(N), .NR_REG(NR_REG)) u_regfile (
        .clk    (clk),
        .rst    (rst),
        .we     (deq && fifo[head].wen),
        .waddr  (fifo[head].rd),
        .wdata  (fifo[head].res),
        .raddr1 (rs1_addr),
        .rdata1 (rf_rdata1),
        .raddr2 (rs2_addr),
        .rdata2 (rf_rdata2)
    );

    always_comb begin
        pend1 = pend_match(rs1_addr);
        pend2 = pend_match(rs2_addr);
`ifdef WBU_BYPASS_EN
        rs1_data   = pend1[N] ? pend1[N-1:0] : rf_rdata1;
        rs2_data   = pend2[N] ? pend2[N-1:0] : rf_rdata2;
        rs1_hazard = 1'b0;
        rs2_hazard = 1'b0;
`else
        rs1_data   = rf_rdata1;
        rs2_data   = rf_rdata2;
        rs1_hazard = pend1[N];
        rs2_hazard = pend2[N];
`endif
    end

endmodule

// File: tb/tb_wbu.sv
// Testbench for wbu: table-driven write/read vectors, a commit scoreboard and
// hand-written stall, forwarding, x0 and mid-operation reset sequences.
module tb_wbu;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, in_wen, wb_stall;
    logic [63:0] in_res, in_pc, rs1_data, rs2_data, commit_pc;
    logic [4:0]  in_rd, rs1_addr, rs2_addr;
    logic        rs1_hazard, rs2_hazard, commit_valid;

    wbu #(.N(64), .NR_REG(32), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_res(in_res), .in_rd(in_rd), .in_wen(in_wen), .in_pc(in_pc),
        .wb_stall(wb_stall), .rs1_addr(rs1_addr), .rs1_data(rs1_data),
        .rs2_addr(rs2_addr), .rs2_data(rs2_data), .rs1_hazard(rs1_hazard),
        .rs2_hazard(rs2_hazard), .commit_valid(commit_valid), .commit_pc(commit_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] pc;
        logic [63:0] res;
        logic [4:0]  rd;
        logic        wen;
    } ent_t;

    typedef struct {
        logic [4:0]  rd;
        logic [63:0] res;
        logic        wen;
        logic [63:0] pc;
        logic [4:0]  chk_addr;
        logic [63:0] chk_exp;
    } vec_t;

    ent_t        mq[$];
    logic [63:0] mreg [32];
    int          n_chk = 0;
    int          n_pass = 0;
    vec_t        vt [6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Reference read: youngest pending writer (bypass) or register + hazard.
    task automatic model_read(input logic [4:0] a, output logic [63:0] d, output logic hz);
        logic        hit;
        logic [63:0] v;
        hit = 1'b0;
        v   = '0;
        foreach (mq[i]) begin
            if (mq[i].wen && mq[i].rd == a && a != 0) begin
                hit = 1'b1;
                v   = mq[i].res;
            end
        end
`ifdef WBU_BYPASS_EN
        d  = hit ? v : mreg[a];
        hz = 1'b0;
`else
        d  = mreg[a];
        hz = hit;
`endif
    endtask

    task automatic check_reads(input logic [4:0] a1, input logic [4:0] a2);
        logic [63:0] d;
        logic        hz;
        rs1_addr = a1;
        rs2_addr = a2;
        #1;
        model_read(a1, d, hz);
        chk("rs1_data", rs1_data, d);
        chk("rs1_hazard", 64'(rs1_hazard), 64'(hz));
        model_read(a2, d, hz);
        chk("rs2_data", rs2_data, d);
        chk("rs2_hazard", 64'(rs2_hazard), 64'(hz));
    endtask

    // One clock: checks ready before the edge, commit result after it.
    task automatic tick();
        logic exp_ready, macc, mdeq;
        ent_t e;
        #1;
        exp_ready = !rst && (mq.size() < DEPTH);
        chk("in_ready", 64'(in_ready), 64'(exp_ready));
        macc = in_valid && exp_ready;
        mdeq = !rst && (mq.size() > 0) && !wb_stall;
        @(posedge clk);
        #1;
        if (rst) begin
            mq.delete();
            for (int i = 0; i < 32; i++) mreg[i] = '0;
            chk("rst_commit_valid", 64'(commit_valid), 64'd0);
            chk("rst_commit_pc", commit_pc, 64'd0);
        end else begin
            if (mdeq) begin
                e = mq.pop_front();
                chk("commit_valid", 64'(commit_valid), 64'd1);
                chk("commit_pc", commit_pc, e.pc);
                if (e.wen && e.rd != 0) mreg[e.rd] = e.res;
            end else begin
                chk("commit_idle", 64'(commit_valid), 64'd0);
            end
            if (macc) mq.push_back('{pc: in_pc, res: in_res, rd: in_rd, wen: in_wen});
        end
    endtask

    task automatic drive(input logic [4:0] rd, input logic [63:0] res, input logic wen,
                         input logic [63:0] pc);
        in_valid = 1'b1;
        in_rd    = rd;
        in_res   = res;
        in_wen   = wen;
        in_pc    = pc;
    endtask

    initial begin
        vt[0] = '{5'd5,  64'h1234,                 1'b1, 64'h8000_0000, 5'd5,  64'h1234};
        vt[1] = '{5'd0,  64'hFFFF_FFFF_FFFF_FFFF,  1'b1, 64'h8000_0004, 5'd0,  64'h0};
        vt[2] = '{5'd3,  64'h55,                   1'b0, 64'h8000_0008, 5'd3,  64'h0};
        vt[3] = '{5'd31, 64'hDEAD_BEEF_CAFE_F00D,  1'b1, 64'h8000_000C, 5'd31, 64'hDEAD_BEEF_CAFE_F00D};
        vt[4] = '{5'd5,  64'h9999,                 1'b1, 64'h8000_0010, 5'd5,  64'h9999};
        vt[5] = '{5'd1,  64'h1,                    1'b1, 64'h8000_0014, 5'd31, 64'hDEAD_BEEF_CAFE_F00D};
        for (int i = 0; i < 32; i++) mreg[i] = '0;

        rst = 1'b1; in_valid = 1'b0; in_res = '0; in_rd = '0; in_wen = 1'b0;
        in_pc = '0; wb_stall = 1'b0; rs1_addr = '0; rs2_addr = '0;
        tick();
        tick();
        rst = 1'b0;
        check_reads(5'd5, 5'd31);

        // Table: write one entry, drain, read back.
        for (int i = 0; i < 6; i++) begin
            drive(vt[i].rd, vt[i].res, vt[i].wen, vt[i].pc);
            tick();
            in_valid = 1'b0;
            tick();
            check_reads(vt[i].chk_addr, 5'd0);
            chk("vec_read", rs1_data, vt[i].chk_exp);
            chk("vec_hazard", 64'(rs1_hazard), 64'd0);
        end

        // Back-to-back stream: simultaneous enqueue and dequeue each edge.
        for (int i = 0; i < 6; i++) begin
            drive(5'(10 + i), 64'(i) * 64'h111 + 64'h7, 1'b1, 64'h9000_0000 + 64'(4 * i));
            tick();
        end
        in_valid = 1'b0;
        tick();
        tick();
        check_reads(5'd10, 5'd15);
        chk("stream_r15", rs2_data, 64'h5 * 64'h111 + 64'h7);

        // Fill under stall, third request refused, then drain in order.
        wb_stall = 1'b1;
        drive(5'd20, 64'hA0, 1'b1, 64'hA000_0000);
        tick();
        drive(5'd21, 64'hA1, 1'b1, 64'hA000_0004);
        tick();
        drive(5'd22, 64'hA2, 1'b1, 64'hA000_0008);
        #1;
        chk("full_ready", 64'(in_ready), 64'd0);
        tick();
        in_valid = 1'b0;
        wb_stall = 1'b0;
        tick();
        chk("drain_first_pc", commit_pc, 64'hA000_0000);
        tick();
        chk("drain_second_pc", commit_pc, 64'hA000_0004);
        tick();
        check_reads(5'd21, 5'd22);
        chk("refused_r22", rs2_data, 64'h0);

        // Two pending writers of r7: youngest wins or hazard raised.
        wb_stall = 1'b1;
        drive(5'd7, 64'hA, 1'b1, 64'hB000_0000);
        tick();
        drive(5'd7, 64'hB, 1'b1, 64'hB000_0004);
        tick();
        in_valid = 1'b0;
        check_reads(5'd0, 5'd7);
`ifdef WBU_BYPASS_EN
        chk("fwd_r7_data", rs2_data, 64'hB);
        chk("fwd_r7_hazard", 64'(rs2_hazard), 64'd0);
`else
        chk("haz_r7_data", rs2_data, 64'h0);
        chk("haz_r7_hazard", 64'(rs2_hazard), 64'd1);
`endif
        chk("x0_hazard", 64'(rs1_hazard), 64'd0);
        wb_stall = 1'b0;
        tick();
        tick();
        tick();
        check_reads(5'd7, 5'd7);
        chk("r7_final", rs1_data, 64'hB);

        // x0 write under stall: never forwarded, never a hazard.
        wb_stall = 1'b1;
        drive(5'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 64'hC000_0000);
        tick();
        in_valid = 1'b0;
        check_reads(5'd0, 5'd0);
        chk("x0_pending_data", rs1_data, 64'h0);
        wb_stall = 1'b0;
        tick();
        chk("x0_commit", 64'(commit_valid), 64'd1);

        // Reset with two entries pending: discarded, no commit.
        wb_stall = 1'b1;
        drive(5'd9, 64'h99, 1'b1, 64'hD000_0000);
        tick();
        drive(5'd5, 64'h77, 1'b1, 64'hD000_0004);
        tick();
        in_valid = 1'b0;
        wb_stall = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("ready_after_rst", 64'(in_ready), 64'd1);
        tick();
        chk("no_commit_after_rst", 64'(commit_valid), 64'd0);
        check_reads(5'd5, 5'd9);
        chk("rst_r5", rs1_data, 64'h0);
        chk("rst_r9", rs2_data, 64'h0);
        check_reads(5'd31, 5'd7);
        chk("rst_r31", rs1_data, 64'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
